// File: rtl/wlif_ctrl.sv
// Spike-to-trace event controller: round-robin event grant, per-channel weights, drop counter.
// Optional refractory hold-off per channel when WLIF_CTRL_REFRAC_EN is defined.
module wlif_ctrl #(
    parameter int unsigned          P_AW     = 2,
    parameter int unsigned          P_WIDTH  = 8,
    parameter logic [P_WIDTH-1:0]   P_WINIT  = 8'd16,
    parameter int unsigned          P_REFRAC = 4
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic [(1<<P_AW)-1:0]              i_spike,
    input  logic                              i_wr_en,
    input  logic [P_AW-1:0]                   i_wr_addr,
    input  logic [P_WIDTH-1:0]                i_wr_data,
    output logic [(1<<P_AW)-1:0]              o_event,
    output logic [(1<<P_AW)*P_WIDTH-1:0]      o_weight,
    output logic [(1<<P_AW)-1:0]              o_pending,
    output logic [7:0]                        o_drop_cnt,
    output logic                              o_busy
);

    localparam int unsigned P_NCH = 1 << P_AW;

    if (P_REFRAC < 1 || P_REFRAC > 255) begin : g_bad_refrac
        $error("wlif_ctrl: P_REFRAC must be in 1..255");
    end

    logic [P_NCH-1:0]   pending;
    logic [P_NCH-1:0]   eligible;
    logic [P_NCH-1:0]   grant;
    logic [P_NCH-1:0]   drops;
    logic [P_AW-1:0]    ptr;
    logic [P_AW-1:0]    gidx;
    logic [P_AW-1:0]    idx;
    logic               found;
    logic [P_AW:0]      ndrop;
    logic [P_AW+8:0]    drop_sum;
    logic [P_WIDTH-1:0] weight [P_NCH];

`ifdef WLIF_CTRL_REFRAC_EN
    logic [7:0] refrac [P_NCH];

    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < P_NCH; i++) begin
            eligible[i] = pending[i] && (refrac[i] == '0);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < P_NCH; i++) begin
                refrac[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < P_NCH; i++) begin
                if (grant[i]) begin
                    refrac[i] <= 8'(P_REFRAC);
                end else if (refrac[i] != '0) begin
                    refrac[i] <= refrac[i] - 8'd1;
                end
            end
        end
    end
`else
    assign eligible = pending;
`endif

    // Scan from the round-robin pointer upward; the P_AW-bit index wraps naturally.
    always_comb begin
        grant = '0;
        found = 1'b0;
        gidx  = '0;
        idx   = '0;
        for (int unsigned i = 0; i < P_NCH; i++) begin
            idx = ptr + P_AW'(i);
            if (!found && eligible[idx]) begin
                found = 1'b1;
                gidx  = idx;
            end
        end
        if (found) begin
            grant[gidx] = 1'b1;
        end
    end

    // A repeat spike is only lost when the channel is already pending and not granted now.
    assign drops = i_spike & pending & ~grant;

    always_comb begin
        ndrop = '0;
        for (int unsigned i = 0; i < P_NCH; i++) begin
            ndrop = ndrop + (P_AW+1)'(drops[i]);
        end
        drop_sum = (P_AW+9)'(o_drop_cnt) + (P_AW+9)'(ndrop);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pending    <= '0;
            o_event    <= '0;
            ptr        <= '0;
            o_drop_cnt <= '0;
            for (int unsigned i = 0; i < P_NCH; i++) begin
                weight[i] <= P_WINIT;
            end
        end else begin
            pending <= (pending & ~grant) | i_spike;
            o_event <= grant;
            if (found) begin
                ptr <= gidx + P_AW'(1);
            end
            o_drop_cnt <= (drop_sum > (P_AW+9)'(255)) ? 8'hFF : drop_sum[7:0];
            if (i_wr_en) begin
                weight[i_wr_addr] <= i_wr_data;
            end
        end
    end

    always_comb begin
        o_weight = '0;
        for (int unsigned i = 0; i < P_NCH; i++) begin
            o_weight[i*P_WIDTH +: P_WIDTH] = weight[i];
        end
    end

    assign o_pending = pending;
    assign o_busy    = |pending;

endmodule
